seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexes NUM_DIGITS BCD digits onto one shared bcd_to_sevensegment_decoder.
- Drives the decoder's A..D, E, CC and CA inputs and a one-hot digit-select bus to the display.
- Digit data is loaded through a valid/ready handshake into a shadow register. It is applied only at frame boundaries, so a frame never shows a mix of old and new digits.
- Sits between the system's display-value source and the decoder/digit-driver pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 1000, clk cycles each digit is lit (>=2).
- BLANK_CYCLES, 2, clk cycles with all digits off before each digit is lit; suppresses ghosting (>=1).

Ports:
- clk, input, 1, system clock; all logic is rising-edge.
- rst, input, 1, synchronous active-high reset.
- enable, input, 1, scanning enable; 0 forces all digits off.
- common_anode, input, 1, display type: 0 = common cathode, 1 = common anode.
- lz_en, input, 1, leading-zero suppression enable.
- load_valid, input, 1, new frame data offered.
- load_ready, output, 1, shadow register free to accept data.
- load_data, input, 4*NUM_DIGITS, BCD digits; digit 0 = bits [3:0] = least significant.
- A, B, C, D, output, 1 each, BCD to decoder (A = MSB).
- E, output, 1, decoder enable.
- CC, CA, output, 1 each, decoder mode pins.
- dig_sel, output, NUM_DIGITS, one-hot digit enable, active-high.
- bcd_err, output, 1, sticky flag: a loaded digit was >9.

Behaviour:
- Reset values:
  - FSM in IDLE; active and shadow registers hold 0; pending = 0; load_ready = 1.
  - A..D = 0, E = 0, dig_sel = 0, bcd_err = 0.
  - CC = 1 and CA = 0 (common-cathode default).
- Reset mid-frame takes effect on the next edge. Any pending shadow data is discarded.
- Handshake:
  - Transfer occurs when load_valid && load_ready at a clk edge. load_data goes to the shadow register and pending is set.
  - load_ready = !pending. It drops the cycle after a transfer.
  - At frame start, shadow is copied to active and pending clears. If load_valid is high at that same edge it is not accepted, because load_ready is still 0; it is accepted on the following cycle.
- Mode latch: common_anode is sampled only on the IDLE->BLANK transition and at each frame start. Then CC = !mode and CA = mode. A mid-frame change has no effect until the next frame.
- FSM states: IDLE, BLANK, SHOW. Digit index k counts 0..NUM_DIGITS-1. A cycle counter is used for BLANK and SHOW.
  - IDLE: dig_sel = 0, E = 0. On enable = 1, go to BLANK with k = 0 and a frame start.
  - BLANK: lasts BLANK_CYCLES cycles. dig_sel = 0, E = 1, A..D = active digit k. Then go to SHOW.
  - SHOW: lasts REFRESH_DIV cycles. dig_sel = one-hot(k) unless digit k is suppressed. Then k = k+1 and go to BLANK.
  - Wrap from k = NUM_DIGITS-1 to k = 0 is a frame start (shadow applied, mode sampled).
  - enable = 0 in any state: go to IDLE on the next edge; dig_sel = 0 that cycle. Counters and k reset.
- Suppression: digit k is not lit (dig_sel stays 0 for the whole SHOW slot, E still 1) if either condition holds:
  - its value is >9;
  - lz_en = 1, k > 0, and digit k and all higher digits are 0.
  - Digit 0 is always shown when its value is valid.
- bcd_err: set when a transfer carries any nibble >9. Cleared only by rst.
- Outputs are registered. dig_sel changes exactly at the state boundaries above.
- Frame period = NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) cycles.

Test Plan:
- Use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1 in all scenarios.
- Basic scan: rst, enable=1, load 0x4321 → per 5-cycle slot: 1 cycle dig_sel=0000, then 4 cycles dig_sel=0001 with ABCD=0001; then 0010 with 0010; then 0100 with 0011; then 1000 with 0100. Frame = 20 cycles, repeating; CC=1, CA=0.
- Frame-boundary update: load 0x5678 mid-frame → load_ready=0 until the next frame start; old digits continue until the k=3 slot ends; the new value is shown from the next k=0; load_ready returns to 1 at the frame start.
- Leading zeros: lz_en=1, load 0x0070 → dig_sel pulses only 0001 (ABCD=0000) and 0010 (ABCD=0111); the slots for k=2,3 keep dig_sel=0. With lz_en=0, all four digits light.
- Invalid BCD + mode: load 0x00A1 → bcd_err=1 and stays set; the k=1 slot shows dig_sel=0. Set common_anode=1 mid-frame → CA=1, CC=0 only from the next frame start.
- Enable/reset mid-operation: enable=0 during SHOW k=2 → the next cycle has dig_sel=0, E=0, IDLE; re-enable restarts at k=0. Assert rst mid-frame with pending data → the next cycle shows all outputs at reset values, load_ready=1, and no pending data is applied.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Multiplexes NUM_DIGITS BCD digits onto one shared seven-segment
//            decoder, with frame-aligned shadow loading and digit blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    common_anode,
    input  logic                    lz_en,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic                    A,
    output logic                    B,
    output logic                    C,
    output logic                    D,
    output logic                    E,
    output logic                    CC,
    output logic                    CA,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    bcd_err
);

    localparam int c_DW   = 4 * NUM_DIGITS;
    localparam int c_KW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int c_CW   = $clog2(c_CMAX);

    localparam logic [c_KW-1:0]       c_K_LAST     = c_KW'(NUM_DIGITS - 1);
    localparam logic [c_CW-1:0]       c_BLANK_LAST = c_CW'(BLANK_CYCLES - 1);
    localparam logic [c_CW-1:0]       c_SHOW_LAST  = c_CW'(REFRESH_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] c_ONE        = NUM_DIGITS'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_KW-1:0]       r_k;
    logic [c_CW-1:0]       r_cnt;
    logic [c_DW-1:0]       r_active;
    logic [c_DW-1:0]       r_shadow;
    logic                  r_pending;
    logic [3:0]            r_bcd;
    logic                  r_e;
    logic                  r_cc;
    logic                  r_ca;
    logic [NUM_DIGITS-1:0] r_dig_sel;
    logic                  r_bcd_err;

    logic                  w_blank_done;
    logic                  w_show_done;
    logic                  w_xfer;
    logic                  w_frame_start;
    logic [c_KW-1:0]       w_k_next;
    logic [c_KW-1:0]       w_abcd_idx;
    logic [c_DW-1:0]       w_active_next;
    logic                  w_load_bad;
    logic                  w_upper_zero;
    logic                  w_suppress;
    logic [3:0]            w_digit;
    logic [3:0]            w_next_digit;
    logic [NUM_DIGITS-1:0] w_sel;

    assign w_blank_done  = (r_cnt == c_BLANK_LAST);
    assign w_show_done   = (r_cnt == c_SHOW_LAST);
    assign w_xfer        = load_valid && !r_pending;
    assign w_k_next      = (r_k == c_K_LAST) ? '0 : r_k + 1'b1;
    assign w_abcd_idx    = (r_state == S_IDLE) ? '0 : w_k_next;
    assign w_frame_start = enable && ((r_state == S_IDLE) ||
                           ((r_state == S_SHOW) && w_show_done && (r_k == c_K_LAST)));
    // The digit presented at a frame start must come from the freshly applied shadow.
    assign w_active_next = (w_frame_start && r_pending) ? r_shadow : r_active;

    always_comb begin
        w_load_bad   = 1'b0;
        w_upper_zero = 1'b1;
        w_digit      = 4'd0;
        w_next_digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (load_data[4*i +: 4] > 4'd9) w_load_bad = 1'b1;
            if (i == int'(r_k)) w_digit = r_active[4*i +: 4];
            if (i == int'(w_abcd_idx)) w_next_digit = w_active_next[4*i +: 4];
            if ((i >= int'(r_k)) && (r_active[4*i +: 4] != 4'd0)) w_upper_zero = 1'b0;
        end
        w_suppress = (w_digit > 4'd9) || (lz_en && (r_k != '0) && w_upper_zero);
        w_sel      = w_suppress ? '0 : (c_ONE << r_k);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_cnt     <= '0;
            r_active  <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_bcd     <= 4'd0;
            r_e       <= 1'b0;
            r_cc      <= 1'b1;
            r_ca      <= 1'b0;
            r_dig_sel <= '0;
            r_bcd_err <= 1'b0;
        end else begin
            // Transfer needs !r_pending and the shadow apply needs r_pending, so they never collide.
            if (w_xfer) begin
                r_shadow  <= load_data;
                r_pending <= 1'b1;
                if (w_load_bad) r_bcd_err <= 1'b1;
            end
            if (w_frame_start) begin
                r_cc <= ~common_anode;
                r_ca <= common_anode;
                if (r_pending) begin
                    r_active  <= r_shadow;
                    r_pending <= 1'b0;
                end
            end

            if (!enable) begin
                r_state   <= S_IDLE;
                r_k       <= '0;
                r_cnt     <= '0;
                r_bcd     <= 4'd0;
                r_e       <= 1'b0;
                r_dig_sel <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state   <= S_BLANK;
                        r_k       <= '0;
                        r_cnt     <= '0;
                        r_bcd     <= w_next_digit;
                        r_e       <= 1'b1;
                        r_dig_sel <= '0;
                    end
                    S_BLANK: begin
                        if (w_blank_done) begin
                            r_state   <= S_SHOW;
                            r_cnt     <= '0;
                            r_dig_sel <= w_sel;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_SHOW: begin
                        if (w_show_done) begin
                            r_state   <= S_BLANK;
                            r_cnt     <= '0;
                            r_k       <= w_k_next;
                            r_bcd     <= w_next_digit;
                            r_dig_sel <= '0;
                        end else begin
                            r_cnt     <= r_cnt + 1'b1;
                            r_dig_sel <= w_sel;
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_k       <= '0;
                        r_cnt     <= '0;
                        r_bcd     <= 4'd0;
                        r_e       <= 1'b0;
                        r_dig_sel <= '0;
                    end
                endcase
            end
        end
    end

    assign load_ready = ~r_pending;
    assign A          = r_bcd[3];
    assign B          = r_bcd[2];
    assign C          = r_bcd[1];
    assign D          = r_bcd[0];
    assign E          = r_e;
    assign CC         = r_cc;
    assign CA         = r_ca;
    assign dig_sel    = r_dig_sel;
    assign bcd_err    = r_bcd_err;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Self-checking bench for seg_scan_ctrl against a frame-position
//            reference model (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int BC    = 1;
    localparam int SLOT  = RD + BC;
    localparam int FRAME = ND * SLOT;
    localparam logic [12:0] RESET_VEC = 13'b1_0000_0_1_0_0000_0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        common_anode = 1'b0;
    logic        lz_en = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0;
    logic        load_ready, A, B, C, D, E, CC, CA, bcd_err;
    logic [3:0]  dig_sel;
    logic [12:0] obs;

    int errors = 0;
    int checks = 0;

    // Reference model: scan position is simply the cycle offset into the frame.
    bit          m_run = 1'b0;
    int          m_t = 0;
    logic [15:0] m_active = 16'h0;
    logic [15:0] m_shadow = 16'h0;
    bit          m_pending = 1'b0;
    bit          m_mode = 1'b0;
    bit          m_err = 1'b0;
    bit          m_lz = 1'b0;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst(rst), .enable(enable), .common_anode(common_anode),
        .lz_en(lz_en), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .A(A), .B(B), .C(C), .D(D), .E(E), .CC(CC),
        .CA(CA), .dig_sel(dig_sel), .bcd_err(bcd_err)
    );

    always #5 clk = ~clk;

    assign obs = {load_ready, A, B, C, D, E, CC, CA, dig_sel, bcd_err};

    function automatic logic [12:0] exp_vec();
        logic [3:0] d, sel, abcd;
        logic       e;
        int         k, ph;
        sel = 4'b0; abcd = 4'b0; e = 1'b0;
        if (m_run) begin
            k    = m_t / SLOT;
            ph   = m_t % SLOT;
            d    = m_active[4*k +: 4];
            abcd = d;
            e    = 1'b1;
            if (ph >= BC && d <= 4'd9 && !(m_lz && k > 0 && (m_active >> (4*k)) == 16'h0))
                sel = 4'b0001 << k;
        end
        return {~m_pending, abcd, e, ~m_mode, m_mode, sel, m_err};
    endfunction

    task automatic cyc();
        bit xfer, fs;
        @(posedge clk);
        if (rst) begin
            m_run = 0; m_t = 0; m_active = 0; m_shadow = 0;
            m_pending = 0; m_mode = 0; m_err = 0; m_lz = 0;
        end else begin
            xfer = load_valid && !m_pending;
            fs   = 0;
            if (!enable) begin
                m_run = 0; m_t = 0;
            end else if (!m_run) begin
                m_run = 1; m_t = 0; fs = 1;
            end else begin
                m_t = (m_t + 1) % FRAME;
                fs  = (m_t == 0);
            end
            if (fs) begin
                m_mode = common_anode;
                if (m_pending) begin m_active = m_shadow; m_pending = 0; end
            end
            if (xfer) begin
                m_shadow  = load_data;
                m_pending = 1;
                for (int j = 0; j < ND; j++) if (load_data[4*j +: 4] > 4'd9) m_err = 1;
            end
            m_lz = lz_en;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (obs !== RESET_VEC) begin
                errors++;
                $display("FAIL reset_state cyc%0d: got %b expected %b", i, obs, RESET_VEC);
            end
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle: got %b expected %b", obs, exp_vec());
        end
    endtask

    task automatic test_basic_scan();
        int cnt[ND];
        for (int k = 0; k < ND; k++) cnt[k] = 0;
        load_data = 16'h4321; load_valid = 1'b1;
        cyc();
        load_valid = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            cyc();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL basic_scan i=%0d: got %b expected %b", i, obs, exp_vec());
            end
            if (i >= FRAME && i < 2 * FRAME)
                for (int k = 0; k < ND; k++) if (dig_sel == (4'b0001 << k)) cnt[k]++;
        end
        for (int k = 0; k < ND; k++) begin
            checks++;
            if (cnt[k] !== RD) begin
                errors++;
                $display("FAIL basic_slot_len k=%0d: got %0d cycles expected %0d", k, cnt[k], RD);
            end
        end
    endtask

    task automatic test_frame_update();
        int guard = 0;
        while (!(m_run && m_t == 7) && guard < 2 * FRAME) begin cyc(); guard++; end
        checks++;
        if (guard >= 2 * FRAME) begin errors++; $display("FAIL frame_update_align: got timeout expected t=7"); end
        load_data = 16'h5678; load_valid = 1'b1;
        cyc();
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) begin errors++; $display("FAIL frame_update_ready: got %b expected 0", load_ready); end
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL frame_update i=%0d: got %b expected %b", i, obs, exp_vec());
            end
            // Offer data across the frame boundary, changing it after the first accept.
            if (i == 15 + FRAME - 8) begin load_data = 16'h1234; load_valid = 1'b1; end
            if (i == 16 + FRAME - 8) load_data = 16'h9876;
            if (i == 24 + FRAME - 8) load_valid = 1'b0;
        end
        for (int i = 0; i < FRAME; i++) begin
            cyc();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL frame_update_tail i=%0d: got %b expected %b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_leading_zeros();
        lz_en = 1'b1;
        load_data = 16'h0070; load_valid = 1'b1;
        cyc();
        load_valid = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (i == 2 * FRAME) lz_en = 1'b0;
            cyc();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL leading_zeros i=%0d lz=%0d: got %b expected %b", i, lz_en, obs, exp_vec());
            end
        end
    endtask

    task automatic test_invalid_mode();
        int guard = 0;
        load_data = 16'h00A1; load_valid = 1'b1;
        cyc();
        load_valid = 1'b0;
        checks++;
        if (bcd_err !== 1'b1) begin errors++; $display("FAIL bcd_err_set: got %b expected 1", bcd_err); end
        while (!(m_run && m_t == 7 && m_active == 16'h00A1) && guard < 3 * FRAME) begin cyc(); guard++; end
        checks++;
        if (guard >= 3 * FRAME) begin errors++; $display("FAIL invalid_align: got timeout expected t=7"); end
        common_anode = 1'b1;
        cyc();
        checks++;
        if (CA !== 1'b0 || CC !== 1'b1) begin
            errors++;
            $display("FAIL mode_midframe: got CC=%b CA=%b expected CC=1 CA=0", CC, CA);
        end
        load_data = 16'h1234; load_valid = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc();
            load_valid = 1'b0;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL invalid_mode i=%0d: got %b expected %b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_enable_reset();
        int guard = 0;
        while (!(m_run && m_t == 2 * SLOT + 2) && guard < 2 * FRAME) begin cyc(); guard++; end
        checks++;
        if (guard >= 2 * FRAME) begin errors++; $display("FAIL enable_align: got timeout expected k=2"); end
        enable = 1'b0;
        cyc();
        checks++;
        if (dig_sel !== 4'b0 || E !== 1'b0) begin
            errors++;
            $display("FAIL enable_off: got dig_sel=%b E=%b expected 0000 0", dig_sel, E);
        end
        for (int i = 0; i < 3 + FRAME; i++) begin
            if (i == 3) enable = 1'b1;
            cyc();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL reenable i=%0d: got %b expected %b", i, obs, exp_vec());
            end
        end
        load_data = 16'h7777; load_valid = 1'b1;
        cyc();
        load_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (obs !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_midframe: got %b expected %b", obs, RESET_VEC);
        end
        for (int i = 0; i < FRAME + 2; i++) begin
            cyc();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL after_reset i=%0d: got %b expected %b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 800; i++) begin
            rst    = ($urandom_range(0, 249) == 0);
            enable = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 39) == 0) lz_en = ~lz_en;
            if ($urandom_range(0, 29) == 0) common_anode = ~common_anode;
            load_valid = ($urandom_range(0, 7) == 0);
            for (int j = 0; j < ND; j++) begin
                r = $urandom_range(0, 39);
                load_data[4*j +: 4] = (r < 16) ? 4'd0 : (r < 39) ? 4'($urandom_range(1, 9))
                                                              : 4'($urandom_range(10, 15));
            end
            cyc();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random i=%0d: got %b expected %b", i, obs, exp_vec());
            end
        end
        rst = 1'b0; load_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_scan();
        test_frame_update();
        test_leading_zeros();
        test_invalid_mode();
        test_enable_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
